clock_manager: RTL
==================

CLOCK_MANAGER -- requirements
Module: clock_manager

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent tick-enable channels, range 1..8.
REQ-002 Parameter DIV_W, default 16: width of each channel divisor and counter.
REQ-003 Parameter STRETCH_CYCLES, default 1024: cycles reset_n_out is held low after lock is seen, minimum 1.
REQ-004 Parameter SYNC_STAGES, default 2: flops in the locked_in synchronizer, minimum 2.
REQ-005 Port clock_in, input, 1: the single clock (PLL output domain); all logic on its rising edge.
REQ-006 Port reset_n, input, 1: synchronous, active-low reset.
REQ-007 Port locked_in, input, 1: PLL lock indication, asynchronous to clock_in.
REQ-008 Port div_in, input, NUM_CH x DIV_W: per-channel divisor, sampled every cycle.
REQ-009 Port lock_lost_clear, input, 1: clears the sticky lock_lost flag.
REQ-010 Port reset_n_out, output, 1: registered, stretched, active-low system reset for downstream logic.
REQ-011 Port tick_out, output, NUM_CH: one-cycle clock-enable pulses, one bit per channel.
REQ-012 Port lock_lost, output, 1: sticky flag, set when lock drops while running.
REQ-013 Port state_out, output, 2: current FSM state encoding, for debug.

Function
REQ-014 locked_in shall pass through SYNC_STAGES flops; the last stage is lock_s, the only lock signal used internally.
REQ-015 FSM states: WAIT_LOCK=0, STRETCH=1, RUN=2; encoding 3 is unused and shall recover to WAIT_LOCK on the next edge.
REQ-016 WAIT_LOCK -> STRETCH on the edge where lock_s=1; the stretch counter is cleared on that edge.
REQ-017 STRETCH shall last exactly STRETCH_CYCLES cycles, then move to RUN.
REQ-018 STRETCH -> WAIT_LOCK if lock_s=0; the stretch counter is cleared and lock_lost is not set.
REQ-019 RUN -> WAIT_LOCK when lock_s=0; lock_lost is set on the same edge.
REQ-020 reset_n_out shall be a register equal to 1 exactly in cycles where the state is RUN; it falls on the edge that leaves RUN.
REQ-021 Latency: locked_in rising before sampling edge k gives reset_n_out=1 after edge k+SYNC_STAGES+STRETCH_CYCLES.
REQ-022 Each channel shall count only while in RUN; otherwise its counter is held at 0 and its tick_out bit at 0.
REQ-023 Channel with div=0 is disabled: counter held at 0, tick 0.
REQ-024 Channel with div=N>=1:
  - tick_out pulses for one cycle when counter >= N-1; the counter then wraps to 0, otherwise it increments.
  - Period is therefore N cycles; div=1 gives a tick every RUN cycle.
REQ-025 A div change that leaves counter >= N-1 shall produce a tick on the next cycle and a wrap, never a counter overflow.
REQ-026 Channels are independent; tick_out bits are registered outputs.
REQ-027 lock_lost_clear=1 clears lock_lost; if set and clear occur on the same edge, set wins.

Reset
REQ-028 When reset_n=0 at an edge:
  - state=WAIT_LOCK, reset_n_out=0, tick_out=0, lock_lost=0.
  - All counters and synchronizer flops are set to 0.
REQ-029 Reset mid-STRETCH or mid-RUN shall abandon the operation fully; after release, lock must be re-synchronized through all SYNC_STAGES.

Structure
REQ-030 Package clock_manager_pkg shall hold the state enum type and the default parameter constants.
REQ-031 Sub-module tick_divider (one channel: counter, compare, tick) shall be instantiated NUM_CH times by generate.
REQ-032 The synchronizer and FSM are inline in clock_manager; no other sub-modules.

Verification
REQ-033 STRETCH_CYCLES=16, SYNC_STAGES=2; locked_in held 1 from edge 0 -> reset_n_out rises after edge 18, state_out=2.
REQ-034 In RUN, div_in={3,1} -> ch0 ticks every 3rd cycle, ch1 ticks every cycle; div=0 on a channel -> its tick stays 0.
REQ-035 ch0 at counter=7 with div 10 changed to 4 -> tick on the next cycle, then period 4.
REQ-036 locked_in drops during RUN -> reset_n_out=0 and lock_lost=1 three edges later, ticks stop; drop during STRETCH -> lock_lost stays 0.
REQ-037 lock_lost_clear asserted on the same edge as a lock drop in RUN -> lock_lost=1; clear alone later -> 0.
REQ-038 reset_n pulsed low for 1 cycle mid-RUN with locked_in=1 -> all outputs 0, then reset_n_out high again 18 edges after release.

Source files
------------

// File: rtl/clock_manager_pkg.sv
// rtl/clock_manager_pkg.sv - shared state type and default parameters for clock_manager
package clock_manager_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } cm_state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_DIV_W          = 16;
  localparam int DEF_STRETCH_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES    = 2;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - one tick-enable channel: counter, compare and registered tick
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic             tick_q;

  // ">=" rather than "==" so a divisor shrunk below the live count wraps instead of overflowing
  always_ff @(posedge clock_in) begin
    if (!reset_n || !run_i || (div_i == '0)) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q >= (div_i - DIV_W'(1))) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + DIV_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clock_manager.sv
// rtl/clock_manager.sv - PLL lock synchronizer, stretched reset FSM and tick-enable channels
module clock_manager
  import clock_manager_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int DIV_W          = DEF_DIV_W,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic                          locked_in,
  input  logic [NUM_CH-1:0][DIV_W-1:0]  div_in,
  input  logic                          lock_lost_clear,
  output logic                          reset_n_out,
  output logic [NUM_CH-1:0]             tick_out,
  output logic                          lock_lost,
  output logic [1:0]                    state_out
);

  localparam int CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  cm_state_e              state_q;
  logic [CNT_W-1:0]       stretch_cnt_q;
  logic                   rst_out_q;
  logic                   lock_lost_q;
  logic                   run;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // The set of lock_lost comes after the clear so a coincident set overrides it
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      stretch_cnt_q <= '0;
      rst_out_q     <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      rst_out_q <= 1'b0;
      if (lock_lost_clear) begin
        lock_lost_q <= 1'b0;
      end
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q       <= STRETCH;
            stretch_cnt_q <= '0;
          end
        end
        STRETCH: begin
          if (!lock_s) begin
            state_q       <= WAIT_LOCK;
            stretch_cnt_q <= '0;
          end else if (stretch_cnt_q == STRETCH_LAST) begin
            state_q       <= RUN;
            stretch_cnt_q <= '0;
            rst_out_q     <= 1'b1;
          end else begin
            stretch_cnt_q <= stretch_cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q     <= WAIT_LOCK;
            lock_lost_q <= 1'b1;
          end else begin
            rst_out_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= WAIT_LOCK;
          stretch_cnt_q <= '0;
        end
      endcase
    end
  end

  assign run = (state_q == RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .run_i   (run),
      .div_i   (div_in[g]),
      .tick_o  (tick_out[g])
    );
  end

  assign reset_n_out = rst_out_q;
  assign lock_lost   = lock_lost_q;
  assign state_out   = state_q;

endmodule
